id_ex_pipe: RTL and testbench

- ID/EX pipeline stage register. Sits directly downstream of the ID-stage decode controller and register file.
- Latches the decoded control bundle, operands, immediate and PC for the EX stage.
- Detects load-use hazards and inserts bubbles. Squashes wrong-path instructions on a taken jump/branch.
- Honours a global pipeline hold. A flush that arrives during hold is remembered and applied once hold releases.

---
 rtl/id_ex_pipe.sv | 167 ++++++++++++++++
 tb/tb_id_ex_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe
// Purpose  : ID/EX pipeline register. Latches the decoded bundle for EX,
//            detects load-use hazards and inserts bubbles, squashes the
//            wrong-path instruction on a taken jump/branch, and defers a
//            flush that arrives while the pipeline is held.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe #(
   parameter int          XLEN       = 32,
   parameter logic [4:0]  NOP_OPCODE = 5'b00100
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            hold,
   input  logic            ex_flush,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [4:0]      id_opcode,
   input  logic [2:0]      id_func3,
   input  logic            id_func7,
   input  logic            id_reg_w_en,
   input  logic            id_mux_jb_source,
   input  logic            id_mux_op1,
   input  logic            id_mux_op2,
   input  logic            id_mux_branch_prapare,
   input  logic            id_mux_write_reg,
   input  logic [3:0]      id_dm_w_en,
   output logic            stall_id,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [4:0]      ex_opcode,
   output logic [2:0]      ex_func3,
   output logic            ex_func7,
   output logic            ex_reg_w_en,
   output logic            ex_mux_jb_source,
   output logic            ex_mux_op1,
   output logic            ex_mux_op2,
   output logic            ex_mux_branch_prapare,
   output logic            ex_mux_write_reg,
   output logic [3:0]      ex_dm_w_en
);

   localparam logic [4:0] c_OP_LOAD  = 5'b00000;
   localparam logic [4:0] c_OP_LUI   = 5'b01101;
   localparam logic [4:0] c_OP_AUIPC = 5'b00101;
   localparam logic [4:0] c_OP_JAL   = 5'b11011;
   localparam logic [4:0] c_OP_R     = 5'b01100;
   localparam logic [4:0] c_OP_S     = 5'b01000;
   localparam logic [4:0] c_OP_B     = 5'b11000;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [4:0]      opcode;
      logic [2:0]      func3;
      logic            func7;
      logic            reg_w_en;
      logic            mux_jb_source;
      logic            mux_op1;
      logic            mux_op2;
      logic            mux_branch_prapare;
      logic            mux_write_reg;
      logic [3:0]      dm_w_en;
   } ex_bundle_t;

   ex_bundle_t ex_q, ex_d, id_w, bubble_w;
   logic       flush_pending_q, flush_pending_d;
   logic       kill_w, ex_load_w, use_rs1_w, use_rs2_w, hazard_w;

   // Bubble doubles as the reset image: a harmless addi x0 with no side effects.
   always_comb begin
      bubble_w               = '0;
      bubble_w.mux_write_reg = 1'b1;
      bubble_w.opcode        = NOP_OPCODE;
   end

   assign id_w = '{valid: 1'b1, pc: id_pc, rs1_data: id_rs1_data,
                   rs2_data: id_rs2_data, imm: id_imm, rs1: id_rs1,
                   rs2: id_rs2, rd: id_rd, opcode: id_opcode,
                   func3: id_func3, func7: id_func7, reg_w_en: id_reg_w_en,
                   mux_jb_source: id_mux_jb_source, mux_op1: id_mux_op1,
                   mux_op2: id_mux_op2,
                   mux_branch_prapare: id_mux_branch_prapare,
                   mux_write_reg: id_mux_write_reg, dm_w_en: id_dm_w_en};

   // Load-use detection against the instruction currently held in EX.
   always_comb begin
      kill_w    = ex_flush | flush_pending_q;
      ex_load_w = ex_q.valid & (ex_q.opcode == c_OP_LOAD) & ex_q.reg_w_en
                  & (ex_q.rd != 5'd0);
      use_rs1_w = id_valid & (id_opcode != c_OP_LUI) & (id_opcode != c_OP_AUIPC)
                  & (id_opcode != c_OP_JAL);
      use_rs2_w = id_valid & ((id_opcode == c_OP_R) | (id_opcode == c_OP_S)
                  | (id_opcode == c_OP_B));
      hazard_w  = ex_load_w & ((use_rs1_w & (id_rs1 == ex_q.rd))
                  | (use_rs2_w & (id_rs2 == ex_q.rd)));
      stall_id  = hazard_w & ~kill_w & rst_n;
   end

   // Next-state selection: hold > kill > hazard > empty slot > advance.
   always_comb begin
      ex_d            = ex_q;
      flush_pending_d = flush_pending_q;
      if (hold) begin
         flush_pending_d = flush_pending_q | ex_flush;
      end else if (kill_w) begin
         ex_d            = bubble_w;
         flush_pending_d = 1'b0;
      end else if (hazard_w || !id_valid) begin
         ex_d = bubble_w;
      end else begin
         ex_d = id_w;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q            <= bubble_w;
         flush_pending_q <= 1'b0;
      end else begin
         ex_q            <= ex_d;
         flush_pending_q <= flush_pending_d;
      end
   end

   assign ex_valid              = ex_q.valid;
   assign ex_pc                 = ex_q.pc;
   assign ex_rs1_data           = ex_q.rs1_data;
   assign ex_rs2_data           = ex_q.rs2_data;
   assign ex_imm                = ex_q.imm;
   assign ex_rs1                = ex_q.rs1;
   assign ex_rs2                = ex_q.rs2;
   assign ex_rd                 = ex_q.rd;
   assign ex_opcode             = ex_q.opcode;
   assign ex_func3              = ex_q.func3;
   assign ex_func7              = ex_q.func7;
   assign ex_reg_w_en           = ex_q.reg_w_en;
   assign ex_mux_jb_source      = ex_q.mux_jb_source;
   assign ex_mux_op1            = ex_q.mux_op1;
   assign ex_mux_op2            = ex_q.mux_op2;
   assign ex_mux_branch_prapare = ex_q.mux_branch_prapare;
   assign ex_mux_write_reg      = ex_q.mux_write_reg;
   assign ex_dm_w_en            = ex_q.dm_w_en;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe
// Purpose  : Self-checking bench for id_ex_pipe with an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [4:0]  opcode;
      logic [2:0]  func3;
      logic        func7;
      logic        reg_w_en;
      logic        mux_jb_source;
      logic        mux_op1;
      logic        mux_op2;
      logic        mux_branch_prapare;
      logic        mux_write_reg;
      logic [3:0]  dm_w_en;
   } bun_t;

   logic clk = 1'b0;
   logic rst_n, hold, ex_flush;
   bun_t ins;

   logic        stall_id, ex_valid, ex_func7, ex_reg_w_en, ex_mux_jb_source;
   logic        ex_mux_op1, ex_mux_op2, ex_mux_branch_prapare, ex_mux_write_reg;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_opcode;
   logic [2:0]  ex_func3;
   logic [3:0]  ex_dm_w_en;

   bun_t dut_w;
   assign dut_w = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1,
                   ex_rs2, ex_rd, ex_opcode, ex_func3, ex_func7, ex_reg_w_en,
                   ex_mux_jb_source, ex_mux_op1, ex_mux_op2,
                   ex_mux_branch_prapare, ex_mux_write_reg, ex_dm_w_en};

   bun_t m_ex;
   logic m_fp;
   bun_t exp_q[$];
   int   n_run  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   id_ex_pipe #(.XLEN(32), .NOP_OPCODE(5'b00100)) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .ex_flush(ex_flush),
      .id_valid(ins.valid), .id_pc(ins.pc), .id_rs1_data(ins.rs1_data),
      .id_rs2_data(ins.rs2_data), .id_imm(ins.imm), .id_rs1(ins.rs1),
      .id_rs2(ins.rs2), .id_rd(ins.rd), .id_opcode(ins.opcode),
      .id_func3(ins.func3), .id_func7(ins.func7), .id_reg_w_en(ins.reg_w_en),
      .id_mux_jb_source(ins.mux_jb_source), .id_mux_op1(ins.mux_op1),
      .id_mux_op2(ins.mux_op2),
      .id_mux_branch_prapare(ins.mux_branch_prapare),
      .id_mux_write_reg(ins.mux_write_reg), .id_dm_w_en(ins.dm_w_en),
      .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
      .ex_func3(ex_func3), .ex_func7(ex_func7), .ex_reg_w_en(ex_reg_w_en),
      .ex_mux_jb_source(ex_mux_jb_source), .ex_mux_op1(ex_mux_op1),
      .ex_mux_op2(ex_mux_op2),
      .ex_mux_branch_prapare(ex_mux_branch_prapare),
      .ex_mux_write_reg(ex_mux_write_reg), .ex_dm_w_en(ex_dm_w_en)
   );

   task automatic chk(input string tag, input logic [255:0] got,
                      input logic [255:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bun_t f_bubble();
      bun_t b;
      b               = '0;
      b.mux_write_reg = 1'b1;
      b.opcode        = 5'b00100;
      return b;
   endfunction

   // True when the instruction i in ID reads the destination of a load in EX.
   function automatic logic f_hazard(bun_t e, bun_t i);
      logic is_load, reads1, reads2;
      is_load = e.valid && e.opcode == 5'b00000 && e.reg_w_en && e.rd != 5'd0;
      reads1  = i.valid && !(i.opcode inside {5'b01101, 5'b00101, 5'b11011});
      reads2  = i.valid && (i.opcode inside {5'b01100, 5'b01000, 5'b11000});
      return is_load && ((reads1 && i.rs1 == e.rd) || (reads2 && i.rs2 == e.rd));
   endfunction

   function automatic bun_t mk(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1,
                               logic [4:0] rs2, logic [31:0] pc,
                               logic [31:0] rs1d);
      bun_t b;
      b                    = '0;
      b.valid              = 1'b1;
      b.opcode             = op;
      b.rd                 = rd;
      b.rs1                = rs1;
      b.rs2                = rs2;
      b.pc                 = pc;
      b.rs1_data           = rs1d;
      b.rs2_data           = $urandom;
      b.imm                = pc + 32'd4;
      b.func3              = 3'($urandom_range(0, 7));
      b.func7              = 1'($urandom_range(0, 1));
      b.reg_w_en           = 1'b1;
      b.mux_op2            = 1'($urandom_range(0, 1));
      b.mux_write_reg      = 1'b1;
      b.mux_jb_source      = 1'($urandom_range(0, 1));
      b.mux_branch_prapare = 1'($urandom_range(0, 1));
      b.dm_w_en            = (op == 5'b01000) ? 4'hF : 4'h0;
      return b;
   endfunction

   // One cycle: check stall_id, predict EX contents, advance, compare.
   task automatic step(input string tag);
      logic exp_stall, haz, nfp;
      bun_t nxt;
      #1;
      haz       = f_hazard(m_ex, ins);
      exp_stall = rst_n && !(ex_flush || m_fp) && haz;
      chk({tag, "_stall"}, {255'd0, stall_id}, {255'd0, exp_stall});
      nfp = m_fp;
      if (!rst_n) begin
         nxt = f_bubble();
         nfp = 1'b0;
      end else if (hold) begin
         nxt = m_ex;
         nfp = m_fp | ex_flush;
      end else if (ex_flush || m_fp) begin
         nxt = f_bubble();
         nfp = 1'b0;
      end else if (haz || !ins.valid) begin
         nxt = f_bubble();
      end else begin
         nxt = ins;
      end
      exp_q.push_back(nxt);
      @(posedge clk);
      #1;
      m_ex = nxt;
      m_fp = nfp;
      if (exp_q.size() == 0) chk({tag, "_queue"}, 256'd0, 256'd1);
      else chk({tag, "_ex"}, {93'd0, dut_w}, {93'd0, exp_q.pop_front()});
   endtask

   initial begin
      bun_t add_i, lw_i;
      m_ex     = f_bubble();
      m_fp     = 1'b0;
      rst_n    = 1'b0;
      hold     = 1'b1;
      ex_flush = 1'b0;
      ins      = bun_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});

      // Reset with hold asserted and garbage in ID.
      step("rst0");
      ins = bun_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      ex_flush = 1'b1;
      step("rst1");
      chk("rst_opcode", {251'd0, ex_opcode}, {251'd0, 5'b00100});
      chk("rst_wreg", {255'd0, ex_mux_write_reg}, 256'd1);
      rst_n = 1'b1; hold = 1'b0; ex_flush = 1'b0;

      // Pass-through of add x3,x1,x2.
      add_i = mk(5'b01100, 5'd3, 5'd1, 5'd2, 32'h100, 32'd5);
      ins = add_i;
      step("pass");
      chk("pass_pc", {224'd0, ex_pc}, {224'd0, 32'h100});
      chk("pass_rs1d", {224'd0, ex_rs1_data}, 256'd5);
      chk("pass_valid", {255'd0, ex_valid}, 256'd1);

      // Load-use: lw x5 then add x6,x5,x1 -> one stall, bubble, then add.
      lw_i = mk(5'b00000, 5'd5, 5'd2, 5'd0, 32'h104, 32'd0);
      ins = lw_i;                                   step("lw1");
      ins = mk(5'b01100, 5'd6, 5'd5, 5'd1, 32'h108, 32'd9);
      step("luse_stall");
      chk("luse_bubble_v", {255'd0, ex_valid}, 256'd0);
      step("luse_go");
      chk("luse_add_pc", {224'd0, ex_pc}, {224'd0, 32'h108});

      // x0 load never stalls.
      ins = mk(5'b00000, 5'd0, 5'd2, 5'd0, 32'h10C, 32'd0);  step("lwx0");
      ins = mk(5'b01100, 5'd6, 5'd0, 5'd0, 32'h110, 32'd0);  step("x0_use");

      // lui does not read rs1; sw reads rs2.
      ins = lw_i;                                             step("lw2");
      ins = mk(5'b01101, 5'd5, 5'd5, 5'd5, 32'h114, 32'd0);  step("lui_nouse");
      ins = lw_i;                                             step("lw3");
      ins = mk(5'b01000, 5'd0, 5'd2, 5'd5, 32'h118, 32'd0);  step("sw_stall");
      step("sw_go");

      // Flush alone, then flush together with a hazard.
      ins = add_i; ex_flush = 1'b1;                           step("flush");
      ex_flush = 1'b0; ins = lw_i;                            step("lw4");
      ins = mk(5'b01100, 5'd6, 5'd5, 5'd1, 32'h11C, 32'd0);
      ex_flush = 1'b1;                                        step("flush_haz");
      ex_flush = 1'b0;                                        step("after_fh");

      // Hold for three cycles with a flush pulse in the first one.
      ins = add_i;                                            step("pre_hold");
      hold = 1'b1; ex_flush = 1'b1;
      ins = mk(5'b01100, 5'd7, 5'd1, 5'd2, 32'h200, 32'd1);   step("hold1");
      ex_flush = 1'b0;                                        step("hold2");
      step("hold3");
      hold = 1'b0;                                            step("hold_rel");
      step("hold_pass");

      // Reset while held with a pending flush clears the pending flush.
      hold = 1'b1; ex_flush = 1'b1;                           step("rh_hold");
      ex_flush = 1'b0; rst_n = 1'b0;                          step("rh_rst");
      rst_n = 1'b1; hold = 1'b0;                              step("rh_pass");

      // Randomised traffic across all control inputs.
      for (int k = 0; k < 200; k++) begin
         logic [4:0] ops[8];
         ops = '{5'b00000, 5'b01100, 5'b01000, 5'b11000,
                 5'b01101, 5'b00101, 5'b11011, 5'b00100};
         ins = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom, $urandom);
         ins.valid    = ($urandom_range(0, 3) != 0);
         ins.reg_w_en = 1'($urandom_range(0, 1)) | (ins.opcode == 5'b00000);
         hold         = ($urandom_range(0, 4) == 0);
         ex_flush     = ($urandom_range(0, 5) == 0);
         rst_n        = ($urandom_range(0, 40) != 0);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
